// File: rtl/ethernet_receive_que_slot.sv
// Receive queue slot: captures one parsed frame, commits or drops it on the CRC verdict, then streams it out.
// Build option ETHERNET_RECEIVE_QUE_SLOT_STRIP_FCS_EN removes the trailing 4-byte FCS from committed frames.
//
// state   | meaning
// S_IDLE  | slot empty, enable high, first valid byte opens a frame
// S_WRITE | capturing bytes, waiting for the good/bad verdict
// S_READ  | streaming the committed frame over valid/ready
module ethernet_receive_que_slot #(
  parameter int BUFFER_DEPTH  = 2048,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [7:0]                    packet_data,
  input  logic                          packet_data_valid,
  input  logic                          good_packet,
  input  logic                          bad_packet,
  input  logic                          frame_data_ready,
  output logic                          recieve_slot_enable,
  output logic [7:0]                    frame_data,
  output logic                          frame_data_valid,
  output logic                          frame_data_last,
  output logic [$clog2(BUFFER_DEPTH):0] frame_length,
  output logic [COUNTER_WIDTH-1:0]      good_frame_count,
  output logic [COUNTER_WIDTH-1:0]      dropped_frame_count
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = AW + 1;
`ifdef ETHERNET_RECEIVE_QUE_SLOT_STRIP_FCS_EN
  localparam int FCS_BYTES = 4;
`else
  localparam int FCS_BYTES = 0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [7:0]    mem [BUFFER_DEPTH];
  logic [CW-1:0] wr_count;
  logic [CW-1:0] rd_ptr;
  logic          overflow;
  logic          buf_full, too_short;
  logic          wr_en, ovf_set, drop, commit, rd_en, rd_done;

  assign buf_full  = (wr_count == CW'(BUFFER_DEPTH));
  // With FCS stripping a frame of FCS_BYTES or fewer has no payload left to commit.
  assign too_short = (wr_count <= CW'(FCS_BYTES));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    ovf_set    = 1'b0;
    drop       = 1'b0;
    commit     = 1'b0;
    rd_en      = 1'b0;
    rd_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (packet_data_valid) begin
          wr_en      = 1'b1;
          next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bad_packet || (good_packet && (overflow || too_short))) begin
          drop       = 1'b1;
          next_state = S_IDLE;
        end else if (good_packet) begin
          commit     = 1'b1;
          next_state = S_READ;
        end else if (packet_data_valid) begin
          if (buf_full) ovf_set = 1'b1;
          else          wr_en   = 1'b1;
        end
      end
      S_READ: begin
        if (frame_data_valid && frame_data_ready && frame_data_last) begin
          rd_done    = 1'b1;
          next_state = S_IDLE;
        end else if (!frame_data_valid || frame_data_ready) begin
          rd_en = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Frame storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_count[AW-1:0]] <= packet_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_count            <= '0;
      overflow            <= 1'b0;
      frame_length        <= '0;
      good_frame_count    <= '0;
      dropped_frame_count <= '0;
    end else begin
      if (wr_en)   wr_count <= wr_count + CW'(1);
      if (ovf_set) overflow <= 1'b1;
      if (drop || commit) begin
        wr_count <= '0;
        overflow <= 1'b0;
      end
      if (commit) begin
        frame_length <= wr_count - CW'(FCS_BYTES);
        if (!(&good_frame_count)) good_frame_count <= good_frame_count + 1'b1;
      end
      if (drop && !(&dropped_frame_count)) dropped_frame_count <= dropped_frame_count + 1'b1;
    end
  end

  // The synchronous read register doubles as the output register, so a stall simply skips the read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr              <= '0;
      frame_data          <= 8'h00;
      frame_data_valid    <= 1'b0;
      frame_data_last     <= 1'b0;
      recieve_slot_enable <= 1'b0;
    end else begin
      if (rd_en) begin
        frame_data       <= mem[rd_ptr[AW-1:0]];
        frame_data_valid <= 1'b1;
        frame_data_last  <= (rd_ptr == frame_length - CW'(1));
        rd_ptr           <= rd_ptr + CW'(1);
      end
      if (rd_done) begin
        frame_data_valid <= 1'b0;
        frame_data_last  <= 1'b0;
        rd_ptr           <= '0;
      end
      recieve_slot_enable <= (next_state == S_IDLE);
    end
  end

endmodule

// File: tb/tb_ethernet_receive_que_slot.sv
// Directed bench for ethernet_receive_que_slot: commit, drop, backpressure, overflow, verdict collision, reset mid-read.
// Expected lengths follow ETHERNET_RECEIVE_QUE_SLOT_STRIP_FCS_EN when it is defined for the build.
module tb_ethernet_receive_que_slot;
  localparam int DEPTH = 2048;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef ETHERNET_RECEIVE_QUE_SLOT_STRIP_FCS_EN
  localparam int FCS = 4;
`else
  localparam int FCS = 0;
`endif
  localparam int SHORT_N   = 3;
  localparam int SHORT_EXP = (SHORT_N > FCS) ? SHORT_N - FCS : 0;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic [7:0]    packet_data = 8'h00;
  logic          packet_data_valid = 1'b0;
  logic          good_packet = 1'b0;
  logic          bad_packet = 1'b0;
  logic          frame_data_ready = 1'b1;
  logic          recieve_slot_enable;
  logic [7:0]    frame_data;
  logic          frame_data_valid;
  logic          frame_data_last;
  logic [LW-1:0] frame_length;
  logic [15:0]   good_frame_count;
  logic [15:0]   dropped_frame_count;

  int total = 0;
  int bad = 0;
  int exp_good = 0;
  int exp_drop = 0;

  logic [7:0] got_data [DEPTH];
  logic       got_last [DEPTH];
  int         n_beats, first_valid, stall_errs, bubbles;
  bit         timed_out;
  int         data_errs, last_errs;

  ethernet_receive_que_slot #(.BUFFER_DEPTH(DEPTH), .COUNTER_WIDTH(16)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .packet_data         (packet_data),
    .packet_data_valid   (packet_data_valid),
    .good_packet         (good_packet),
    .bad_packet          (bad_packet),
    .frame_data_ready    (frame_data_ready),
    .recieve_slot_enable (recieve_slot_enable),
    .frame_data          (frame_data),
    .frame_data_valid    (frame_data_valid),
    .frame_data_last     (frame_data_last),
    .frame_length        (frame_length),
    .good_frame_count    (good_frame_count),
    .dropped_frame_count (dropped_frame_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      packet_data       = 8'(base + i);
      packet_data_valid = 1'b1;
      step();
    end
    packet_data_valid = 1'b0;
    packet_data       = 8'h00;
  endtask

  task automatic verdict(input logic g, input logic b);
    good_packet = g;
    bad_packet  = b;
    step();
    good_packet = 1'b0;
    bad_packet  = 1'b0;
  endtask

  // Capture beats; mode 0 holds ready high, mode 1 drives ready 1,0,0,1 repeating.
  task automatic drain(input int max_beats, input int mode, input int budget);
    int         cyc = 0;
    int         phase = 0;
    logic [7:0] hold_d = 8'h00;
    logic       hold_l = 1'b0;
    bit         stalled = 0, started = 0, rdy, xfer_last;
    n_beats = 0; first_valid = -1; stall_errs = 0; bubbles = 0; timed_out = 0;
    while (1) begin
      if (cyc >= budget) begin
        timed_out = 1;
        break;
      end
      if (stalled && (frame_data_valid !== 1'b1 || frame_data !== hold_d || frame_data_last !== hold_l))
        stall_errs++;
      rdy = (mode == 0) ? 1'b1 : ((phase % 4 == 0) || (phase % 4 == 3));
      phase++;
      frame_data_ready = rdy;
      xfer_last = 0;
      stalled   = 0;
      if (frame_data_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        started = 1;
        if (rdy) begin
          got_data[n_beats] = frame_data;
          got_last[n_beats] = frame_data_last;
          n_beats++;
          xfer_last = frame_data_last;
        end else begin
          stalled = 1;
          hold_d  = frame_data;
          hold_l  = frame_data_last;
        end
      end else if (started) begin
        bubbles++;
      end
      step();
      cyc++;
      if (xfer_last || n_beats >= max_beats) break;
    end
    frame_data_ready = 1'b1;
  endtask

  // Counts captured beats whose data or last flag disagree with an incrementing pattern of length exp_n.
  task automatic score(input int base, input int exp_n);
    data_errs = 0;
    last_errs = 0;
    for (int i = 0; i < n_beats; i++) begin
      if (got_data[i] !== 8'(base + i)) data_errs++;
      if (got_last[i] !== (i == exp_n - 1)) last_errs++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    total++; if (recieve_slot_enable !== 1'b0) begin bad++; $display("FAIL reset enable: got %0b expected 0", recieve_slot_enable); end
    total++; if (frame_data_valid !== 1'b0 || frame_data_last !== 1'b0) begin bad++; $display("FAIL reset valid/last: got %0b/%0b expected 0/0", frame_data_valid, frame_data_last); end
    total++; if (frame_data !== 8'h00 || frame_length !== '0) begin bad++; $display("FAIL reset data/length: got %0h/%0d expected 0/0", frame_data, frame_length); end
    total++; if (good_frame_count !== 16'd0 || dropped_frame_count !== 16'd0) begin bad++; $display("FAIL reset counters: got %0d/%0d expected 0/0", good_frame_count, dropped_frame_count); end
    step();
    step();
    total++; if (recieve_slot_enable !== 1'b0) begin bad++; $display("FAIL reset enable held: got %0b expected 0", recieve_slot_enable); end
    reset_n = 1'b1;
    step();
    total++; if (recieve_slot_enable !== 1'b1) begin bad++; $display("FAIL reset release enable: got %0b expected 1", recieve_slot_enable); end
  endtask

  task automatic test_good_frame();
    send_frame(64, 8'h00);
    total++; if (recieve_slot_enable !== 1'b0) begin bad++; $display("FAIL good64 enable during write: got %0b expected 0", recieve_slot_enable); end
    verdict(1'b1, 1'b0);
    exp_good++;
    drain(64, 0, 300);
    score(8'h00, 64 - FCS);
    total++; if (timed_out) begin bad++; $display("FAIL good64 timeout: got beats %0d expected %0d", n_beats, 64 - FCS); end
    total++; if (first_valid !== 1) begin bad++; $display("FAIL good64 latency: got %0d expected 1", first_valid); end
    total++; if (n_beats !== 64 - FCS) begin bad++; $display("FAIL good64 beats: got %0d expected %0d", n_beats, 64 - FCS); end
    total++; if (data_errs !== 0 || last_errs !== 0) begin bad++; $display("FAIL good64 data/last: got errors %0d/%0d expected 0/0", data_errs, last_errs); end
    total++; if (bubbles !== 0) begin bad++; $display("FAIL good64 bubbles: got %0d expected 0", bubbles); end
    total++; if (frame_length !== LW'(64 - FCS)) begin bad++; $display("FAIL good64 length: got %0d expected %0d", frame_length, 64 - FCS); end
    total++; if (frame_data_valid !== 1'b0 || recieve_slot_enable !== 1'b1) begin bad++; $display("FAIL good64 after last: got valid %0b enable %0b expected 0 1", frame_data_valid, recieve_slot_enable); end
    total++; if (good_frame_count !== 16'(exp_good)) begin bad++; $display("FAIL good64 count: got %0d expected %0d", good_frame_count, exp_good); end
  endtask

  task automatic test_bad_frame();
    send_frame(100, 8'h10);
    verdict(1'b0, 1'b1);
    exp_drop++;
    total++; if (recieve_slot_enable !== 1'b1) begin bad++; $display("FAIL bad100 enable: got %0b expected 1", recieve_slot_enable); end
    drain(1, 0, 20);
    total++; if (first_valid !== -1) begin bad++; $display("FAIL bad100 valid seen: got cycle %0d expected none", first_valid); end
    total++; if (dropped_frame_count !== 16'(exp_drop)) begin bad++; $display("FAIL bad100 dropped: got %0d expected %0d", dropped_frame_count, exp_drop); end
    send_frame(60, 8'h40);
    verdict(1'b1, 1'b0);
    exp_good++;
    drain(60, 0, 300);
    score(8'h40, 60 - FCS);
    total++; if (n_beats !== 60 - FCS || timed_out) begin bad++; $display("FAIL after-bad60 beats: got %0d expected %0d", n_beats, 60 - FCS); end
    total++; if (data_errs !== 0 || last_errs !== 0) begin bad++; $display("FAIL after-bad60 data/last: got errors %0d/%0d expected 0/0", data_errs, last_errs); end
    total++; if (good_frame_count !== 16'(exp_good)) begin bad++; $display("FAIL after-bad60 count: got %0d expected %0d", good_frame_count, exp_good); end
  endtask

  task automatic test_backpressure();
    send_frame(10, 8'hA0);
    verdict(1'b1, 1'b0);
    exp_good++;
    drain(10, 1, 100);
    score(8'hA0, 10 - FCS);
    total++; if (n_beats !== 10 - FCS || timed_out) begin bad++; $display("FAIL bp10 beats: got %0d expected %0d", n_beats, 10 - FCS); end
    total++; if (data_errs !== 0) begin bad++; $display("FAIL bp10 order: got errors %0d expected 0", data_errs); end
    total++; if (last_errs !== 0) begin bad++; $display("FAIL bp10 last: got errors %0d expected 0", last_errs); end
    total++; if (stall_errs !== 0) begin bad++; $display("FAIL bp10 stall stability: got errors %0d expected 0", stall_errs); end
  endtask

  task automatic test_overflow();
    send_frame(DEPTH + 5, 8'h00);
    verdict(1'b1, 1'b0);
    exp_drop++;
    drain(1, 0, 20);
    total++; if (first_valid !== -1) begin bad++; $display("FAIL overflow valid seen: got cycle %0d expected none", first_valid); end
    total++; if (dropped_frame_count !== 16'(exp_drop) || good_frame_count !== 16'(exp_good)) begin bad++; $display("FAIL overflow counts: got %0d/%0d expected %0d/%0d", dropped_frame_count, good_frame_count, exp_drop, exp_good); end
  endtask

  task automatic test_full_frame();
    send_frame(DEPTH, 8'h00);
    verdict(1'b1, 1'b0);
    exp_good++;
    drain(DEPTH, 0, DEPTH + 20);
    score(8'h00, DEPTH - FCS);
    total++; if (n_beats !== DEPTH - FCS || timed_out) begin bad++; $display("FAIL full beats: got %0d expected %0d", n_beats, DEPTH - FCS); end
    total++; if (data_errs !== 0 || last_errs !== 0) begin bad++; $display("FAIL full data/last: got errors %0d/%0d expected 0/0", data_errs, last_errs); end
    total++; if (frame_length !== LW'(DEPTH - FCS)) begin bad++; $display("FAIL full length: got %0d expected %0d", frame_length, DEPTH - FCS); end
  endtask

  task automatic test_both_verdicts();
    send_frame(20, 8'h55);
    verdict(1'b1, 1'b1);
    exp_drop++;
    drain(1, 0, 20);
    total++; if (first_valid !== -1) begin bad++; $display("FAIL both valid seen: got cycle %0d expected none", first_valid); end
    total++; if (dropped_frame_count !== 16'(exp_drop) || good_frame_count !== 16'(exp_good)) begin bad++; $display("FAIL both counts: got %0d/%0d expected %0d/%0d", dropped_frame_count, good_frame_count, exp_drop, exp_good); end
  endtask

  task automatic test_short_frame();
    send_frame(SHORT_N, 8'hC0);
    verdict(1'b1, 1'b0);
    if (SHORT_EXP > 0) exp_good++;
    else               exp_drop++;
    drain((SHORT_EXP > 0) ? SHORT_EXP : 1, 0, 30);
    total++; if (n_beats !== SHORT_EXP) begin bad++; $display("FAIL short beats: got %0d expected %0d", n_beats, SHORT_EXP); end
    total++; if (dropped_frame_count !== 16'(exp_drop) || good_frame_count !== 16'(exp_good)) begin bad++; $display("FAIL short counts: got %0d/%0d expected %0d/%0d", dropped_frame_count, good_frame_count, exp_drop, exp_good); end
  endtask

  task automatic test_reset_mid_read();
    send_frame(64, 8'h00);
    verdict(1'b1, 1'b0);
    drain(30, 0, 100);
    total++; if (n_beats !== 30 || frame_data_valid !== 1'b1) begin bad++; $display("FAIL midread progress: got beats %0d valid %0b expected 30 1", n_beats, frame_data_valid); end
    reset_n = 1'b0;
    #1;
    total++; if (frame_data_valid !== 1'b0 || frame_data_last !== 1'b0 || frame_data !== 8'h00) begin bad++; $display("FAIL midread reset outputs: got valid %0b last %0b data %0h expected 0 0 0", frame_data_valid, frame_data_last, frame_data); end
    total++; if (recieve_slot_enable !== 1'b0 || frame_length !== '0) begin bad++; $display("FAIL midread reset enable/length: got %0b/%0d expected 0/0", recieve_slot_enable, frame_length); end
    step();
    reset_n = 1'b1;
    step();
    exp_good = 0;
    exp_drop = 0;
    total++; if (recieve_slot_enable !== 1'b1 || good_frame_count !== 16'd0 || dropped_frame_count !== 16'd0) begin bad++; $display("FAIL midread release: got enable %0b counts %0d/%0d expected 1 0/0", recieve_slot_enable, good_frame_count, dropped_frame_count); end
    send_frame(68, 8'h80);
    verdict(1'b1, 1'b0);
    exp_good++;
    drain(68, 0, 300);
    score(8'h80, 68 - FCS);
    total++; if (n_beats !== 68 - FCS || timed_out) begin bad++; $display("FAIL post-reset68 beats: got %0d expected %0d", n_beats, 68 - FCS); end
    total++; if (data_errs !== 0 || last_errs !== 0) begin bad++; $display("FAIL post-reset68 data/last: got errors %0d/%0d expected 0/0", data_errs, last_errs); end
    total++; if (frame_length !== LW'(68 - FCS) || good_frame_count !== 16'(exp_good)) begin bad++; $display("FAIL post-reset68 length/count: got %0d/%0d expected %0d/%0d", frame_length, good_frame_count, 68 - FCS, exp_good); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_backpressure();
    test_short_frame();
    test_overflow();
    test_both_verdicts();
    test_full_frame();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ethernet_receive_que_slot.md
Name: ethernet_receive_que_slot

Overview:
- One receive queue slot downstream of the Ethernet packet parser.
- Captures the byte stream the parser steers to this slot and holds it until the parser's CRC verdict arrives.
- On good_packet, commits the frame and streams it out over a valid/ready interface. On bad_packet, discards it.
- One instance per slot. Its recieve_slot_enable output feeds the parser's slot-enable vector.

Parameters:
- BUFFER_DEPTH, 2048, byte capacity of the frame buffer; must be a power of two and at least 64.
- COUNTER_WIDTH, 16, width of the statistics counters.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- packet_data  input  8  frame byte from the parser
- packet_data_valid  input  1  this slot's bit of the parser packet_data_valid vector
- good_packet  input  1  this slot's bit of the parser good_packet vector; single-cycle pulse
- bad_packet  input  1  this slot's bit of the parser bad_packet vector; single-cycle pulse
- frame_data_ready  input  1  downstream accepts frame_data this cycle
- recieve_slot_enable  output  1  slot is empty and can accept a new frame
- frame_data  output  8  committed frame byte
- frame_data_valid  output  1  frame_data is valid
- frame_data_last  output  1  marks the final byte of the frame
- frame_length  output  $clog2(BUFFER_DEPTH)+1  byte count of the frame being streamed
- good_frame_count  output  COUNTER_WIDTH  frames committed, saturating
- dropped_frame_count  output  COUNTER_WIDTH  frames discarded, saturating

Behaviour:
- Reset (asynchronous, reset_n low): state S_IDLE. Write pointer, read pointer, length and overflow flag are 0.
- Output reset values: recieve_slot_enable=0 while reset_n is low, then 1 on the first clock after release. frame_data=0, frame_valid/last=0, frame_length=0, both counters=0.
- Buffer contents are discarded on reset, including reset mid-write or mid-read.
- State S_IDLE:
  - recieve_slot_enable=1.
  - On packet_data_valid: write the byte at address 0, set write count to 1, go to S_WRITE.
  - good_packet and bad_packet are ignored.
- State S_WRITE:
  - recieve_slot_enable=0.
  - Each packet_data_valid writes one byte at the write count, then the count increments.
  - When the count equals BUFFER_DEPTH, further bytes are not written and the overflow flag is set.
  - If bad_packet is seen, or good_packet and bad_packet are seen in the same cycle: clear the write count and overflow flag, increment dropped_frame_count, go to S_IDLE. bad_packet wins over good_packet.
  - On good_packet alone, discard exactly as for bad_packet if the overflow flag is set or the count is 0 (the zero-length case is counted as a drop).
  - Otherwise, on good_packet: latch frame_length=count, increment good_frame_count, go to S_READ.
  - A packet_data_valid in the same cycle as the verdict is not written.
- State S_READ:
  - recieve_slot_enable=0.
  - The buffer uses a synchronous read, one cycle latency.
  - frame_data_valid first asserts 2 cycles after the good_packet cycle.
  - Output register rules:
    - frame_data, frame_data_valid and frame_data_last hold stable while valid=1 and ready=0.
    - A transfer occurs on valid&&ready.
    - With ready held at 1, valid stays high continuously: one byte per clock, no bubbles.
  - frame_data_last=1 only on byte index frame_length-1.
  - The cycle after the last byte transfers: valid=0, read pointer reset, go to S_IDLE.
  - packet_data_valid, good_packet and bad_packet are ignored in this state.
- Counters saturate at all-ones and never wrap.
- Address arithmetic uses $clog2(BUFFER_DEPTH) bits. The count uses one extra bit so the full condition is representable.

Optional Feature:
- Macro: ETHERNET_RECEIVE_QUE_SLOT_STRIP_FCS_EN.
- Defined:
  - The committed frame excludes its last 4 bytes (the FCS): frame_length=count-4 and frame_data_last is on index count-5.
  - A good_packet with count<=4 is discarded and counted as dropped.
- Undefined:
  - The FCS bytes are streamed out as ordinary data and frame_length=count.

Test Plan:
- 64-byte frame (bytes 0x00..0x3F), then good_packet, ready=1:
  - valid rises 2 cycles after good_packet.
  - 64 consecutive beats, data 0x00..0x3F, last on 0x3F.
  - frame_length=64, good_frame_count=1, recieve_slot_enable=1 the cycle after the last beat.
- 100-byte frame, then bad_packet:
  - No valid ever asserts.
  - dropped_frame_count=1, recieve_slot_enable returns to 1 the cycle after bad_packet.
  - A following 60-byte good frame streams intact.
- Backpressure: 10-byte frame with ready toggling 1,0,0,1 repeating:
  - Every byte is delivered exactly once, in order.
  - Data stable during each stall.
  - last asserted only on byte 10.
- Overflow: BUFFER_DEPTH+5 bytes, then good_packet:
  - Frame discarded, dropped_frame_count=1, no valid.
- good_packet and bad_packet in the same cycle after 20 bytes:
  - Dropped, good_frame_count unchanged.
- Reset asserted mid-read at byte 30 of 64:
  - All outputs immediately at their reset values.
  - After release, slot empty, enable=1, counters=0.
  - With STRIP_FCS_EN: 68-byte frame streams 64 bytes, frame_length=64.
